// File: rtl/upc_loop_monitor_pkg.sv
// Shared types and constants for the loop/module activity monitor.
// Used by upc_loop_monitor and its saturating counter instances.
package upc_loop_monitor_pkg;

    typedef enum logic [1:0] {
        LS_IDLE      = 2'd0,
        LS_RUN       = 2'd1,
        LS_WAIT_CONT = 2'd2,
        LS_FROZEN    = 2'd3
    } loop_state_t;

    localparam int DEFAULT_CNT_W = 32;
    localparam int INFLIGHT_W    = 8;

    // Slots of the generated counter bank
    localparam int CI_ITER  = 0;
    localparam int CI_INV   = 1;
    localparam int CI_TRIP  = 2;
    localparam int CI_RUNS  = 3;
    localparam int CI_MCYC  = 4;
    localparam int NUM_CNT  = 5;

endpackage

// File: rtl/upc_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// clr and reset both return it to zero; clr wins over inc.
module upc_sat_counter #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/upc_loop_monitor.sv
// Observes a pipelined loop FSM and its enclosing module, collecting iteration,
// invocation and activity statistics. Define UPC_LOOP_MONITOR_STALL_EN to count stalls.
module upc_loop_monitor
    import upc_loop_monitor_pkg::*;
#(
    parameter int STATE_W = 1,
    parameter int CNT_W   = DEFAULT_CNT_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  finish,
    input  logic [STATE_W-1:0]    cur_state,
    input  logic [STATE_W-1:0]    iter_start_state,
    input  logic [STATE_W-1:0]    iter_end_state,
    input  logic [STATE_W-1:0]    quit_state,
    input  logic                  iter_start_block,
    input  logic                  iter_end_block,
    input  logic                  quit_block,
    input  logic                  iter_start_enable,
    input  logic                  iter_end_enable,
    input  logic                  quit_enable,
    input  logic                  loop_start,
    input  logic                  loop_ready,
    input  logic                  loop_done,
    input  logic                  loop_continue,
    input  logic                  quit_at_end,
    input  logic                  ap_start,
    input  logic                  ap_ready,
    input  logic                  ap_done,
    input  logic                  ap_continue,
    output logic [1:0]            loop_state,
    output logic                  mod_busy,
    output logic                  frozen,
    output logic [CNT_W-1:0]      iter_total,
    output logic [CNT_W-1:0]      invocations,
    output logic [CNT_W-1:0]      last_trip,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      mod_runs,
    output logic [CNT_W-1:0]      mod_cycles,
    output logic [INFLIGHT_W-1:0] inflight
);

    loop_state_t           state_reg, state_next;
    logic [INFLIGHT_W-1:0] inflight_reg, inflight_next;
    logic [CNT_W-1:0]      last_trip_reg, last_trip_next;
    logic                  mod_busy_reg, mod_busy_next;
    logic                  frozen_reg;

    logic s_ev, e_ev, q_ev;
    logic live, close_ev, inv_start;
    logic [CNT_W-1:0] trip_val, trip_plus;

    logic [NUM_CNT-1:0] cnt_inc, cnt_clr;
    logic [CNT_W-1:0]   cnt_val [NUM_CNT];

    // Handshake outputs that carry no state information for this monitor
    logic unused_inputs;
    assign unused_inputs = &{1'b0, loop_ready, ap_ready};

    assign s_ev = (cur_state == iter_start_state) && !iter_start_block && iter_start_enable;
    assign e_ev = (cur_state == iter_end_state)   && !iter_end_block   && iter_end_enable;
    assign q_ev = (cur_state == quit_state)       && !quit_block       && quit_enable;

    // Statistics move only while not frozen and not being frozen this cycle
    assign live = !finish && (state_reg != LS_FROZEN);

    assign trip_val  = cnt_val[CI_TRIP];
    assign trip_plus = (trip_val == '1) ? trip_val : trip_val + 1'b1;

    always_comb begin
        state_next     = state_reg;
        inflight_next  = inflight_reg;
        last_trip_next = last_trip_reg;
        inv_start      = 1'b0;
        close_ev       = 1'b0;
        if (finish) begin
            state_next = LS_FROZEN;
        end else begin
            case (state_reg)
                LS_IDLE: begin
                    if (loop_start) begin
                        inv_start  = 1'b1;
                        state_next = LS_RUN;
                    end
                end
                LS_RUN: begin
                    close_ev = loop_done || (!quit_at_end && q_ev);
                    if (close_ev) begin
                        last_trip_next = s_ev ? trip_plus : trip_val;
                        inflight_next  = '0;
                        state_next     = loop_continue ? LS_IDLE : LS_WAIT_CONT;
                    end else if (s_ev && !e_ev && (inflight_reg != '1)) begin
                        inflight_next = inflight_reg + 1'b1;
                    end else if (e_ev && !s_ev && (inflight_reg != '0)) begin
                        inflight_next = inflight_reg - 1'b1;
                    end
                end
                LS_WAIT_CONT: begin
                    if (loop_continue) begin
                        if (loop_start) begin
                            inv_start  = 1'b1;
                            state_next = LS_RUN;
                        end else begin
                            state_next = LS_IDLE;
                        end
                    end
                end
                default: state_next = LS_FROZEN;
            endcase
        end
    end

    always_comb begin
        mod_busy_next = mod_busy_reg;
        if (live) begin
            if (!mod_busy_reg && ap_start) begin
                mod_busy_next = 1'b1;
            end else if (mod_busy_reg && ap_done && ap_continue) begin
                mod_busy_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= LS_IDLE;
            inflight_reg  <= '0;
            last_trip_reg <= '0;
            mod_busy_reg  <= 1'b0;
            frozen_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            inflight_reg  <= inflight_next;
            last_trip_reg <= last_trip_next;
            mod_busy_reg  <= mod_busy_next;
            if (finish) begin
                frozen_reg <= 1'b1;
            end
        end
    end

    assign cnt_inc[CI_ITER] = live && (state_reg == LS_RUN) && s_ev;
    assign cnt_inc[CI_TRIP] = live && (state_reg == LS_RUN) && s_ev;
    assign cnt_inc[CI_INV]  = inv_start;
    assign cnt_inc[CI_RUNS] = live && !mod_busy_reg && ap_start;
    assign cnt_inc[CI_MCYC] = live && mod_busy_reg;

    // Only the per-invocation trip count is ever cleared outside reset
    assign cnt_clr[CI_ITER] = 1'b0;
    assign cnt_clr[CI_TRIP] = inv_start;
    assign cnt_clr[CI_INV]  = 1'b0;
    assign cnt_clr[CI_RUNS] = 1'b0;
    assign cnt_clr[CI_MCYC] = 1'b0;

    generate
        for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
            upc_sat_counter #(.W(CNT_W)) u_cnt (
                .clock (clock),
                .reset (reset),
                .clr   (cnt_clr[gi]),
                .inc   (cnt_inc[gi]),
                .count (cnt_val[gi])
            );
        end
    endgenerate

`ifdef UPC_LOOP_MONITOR_STALL_EN
    logic stall_inc;
    assign stall_inc = live && (state_reg == LS_RUN) && (cur_state == iter_start_state)
                       && iter_start_enable && iter_start_block;
    upc_sat_counter #(.W(CNT_W)) u_stall (
        .clock (clock),
        .reset (reset),
        .clr   (1'b0),
        .inc   (stall_inc),
        .count (stall_cycles)
    );
`else
    assign stall_cycles = '0;
`endif

    assign loop_state  = state_reg;
    assign inflight    = inflight_reg;
    assign last_trip   = last_trip_reg;
    assign mod_busy    = mod_busy_reg;
    assign frozen      = frozen_reg;
    assign iter_total  = cnt_val[CI_ITER];
    assign invocations = cnt_val[CI_INV];
    assign mod_runs    = cnt_val[CI_RUNS];
    assign mod_cycles  = cnt_val[CI_MCYC];

endmodule

// File: tb/tb_upc_loop_monitor.sv
// Scoreboard bench for upc_loop_monitor: a behavioural model queues the expected
// outputs for every cycle, and a monitor compares them after each rising edge.
module tb_upc_loop_monitor;

    localparam int STATE_W = 2;
    localparam int CNT_W   = 4;
    localparam int CMAX    = 15;
    localparam int IMAX    = 255;

    logic clock = 1'b0;
    logic reset, finish;
    logic [STATE_W-1:0] cur_state, iter_start_state, iter_end_state, quit_state;
    logic iter_start_block, iter_end_block, quit_block;
    logic iter_start_enable, iter_end_enable, quit_enable;
    logic loop_start, loop_ready, loop_done, loop_continue, quit_at_end;
    logic ap_start, ap_ready, ap_done, ap_continue;
    logic [1:0] loop_state;
    logic mod_busy, frozen;
    logic [CNT_W-1:0] iter_total, invocations, last_trip, stall_cycles, mod_runs, mod_cycles;
    logic [7:0] inflight;

    upc_loop_monitor #(.STATE_W(STATE_W), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .finish(finish), .cur_state(cur_state),
        .iter_start_state(iter_start_state), .iter_end_state(iter_end_state),
        .quit_state(quit_state), .iter_start_block(iter_start_block),
        .iter_end_block(iter_end_block), .quit_block(quit_block),
        .iter_start_enable(iter_start_enable), .iter_end_enable(iter_end_enable),
        .quit_enable(quit_enable), .loop_start(loop_start), .loop_ready(loop_ready),
        .loop_done(loop_done), .loop_continue(loop_continue), .quit_at_end(quit_at_end),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
        .ap_continue(ap_continue), .loop_state(loop_state), .mod_busy(mod_busy),
        .frozen(frozen), .iter_total(iter_total), .invocations(invocations),
        .last_trip(last_trip), .stall_cycles(stall_cycles), .mod_runs(mod_runs),
        .mod_cycles(mod_cycles), .inflight(inflight)
    );

    always #5 clock = ~clock;

    typedef struct {
        int st; int infl; int last; int total; int inv;
        int stall; int runs; int mcyc; int busy; int frz;
    } exp_t;

    exp_t expq[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain integers, clamped arithmetic
    int m_st, m_infl, m_last, m_total, m_inv, m_trip, m_stall, m_runs, m_mcyc, m_busy, m_frz;

    function automatic int sat(input int v, input int mx);
        return (v < mx) ? v + 1 : mx;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_step();
        bit s, e, q, close, was_busy;
        exp_t x;
        s = (cur_state == iter_start_state) && !iter_start_block && iter_start_enable;
        e = (cur_state == iter_end_state) && !iter_end_block && iter_end_enable;
        q = (cur_state == quit_state) && !quit_block && quit_enable;
        if (reset) begin
            m_st = 0; m_infl = 0; m_last = 0; m_total = 0; m_inv = 0; m_trip = 0;
            m_stall = 0; m_runs = 0; m_mcyc = 0; m_busy = 0; m_frz = 0;
        end else if (m_frz != 0 || finish) begin
            m_frz = 1;
            m_st  = 3;
        end else begin
            was_busy = (m_busy != 0);
            case (m_st)
                0: if (loop_start) begin m_st = 1; m_inv = sat(m_inv, CMAX); m_trip = 0; end
                1: begin
`ifdef UPC_LOOP_MONITOR_STALL_EN
                    if (cur_state == iter_start_state && iter_start_enable && iter_start_block)
                        m_stall = sat(m_stall, CMAX);
`endif
                    if (s) begin m_trip = sat(m_trip, CMAX); m_total = sat(m_total, CMAX); end
                    close = quit_at_end ? loop_done : (loop_done || q);
                    if (close) begin
                        m_last = m_trip;
                        m_infl = 0;
                        m_st   = loop_continue ? 0 : 2;
                    end else if (s && !e) begin
                        m_infl = sat(m_infl, IMAX);
                    end else if (e && !s && m_infl > 0) begin
                        m_infl = m_infl - 1;
                    end
                end
                2: if (loop_continue) begin
                    if (loop_start) begin m_st = 1; m_inv = sat(m_inv, CMAX); m_trip = 0; end
                    else m_st = 0;
                end
                default: ;
            endcase
            if (!was_busy && ap_start) begin
                m_busy = 1; m_runs = sat(m_runs, CMAX);
            end else if (was_busy && ap_done && ap_continue) begin
                m_busy = 0;
            end
            if (was_busy) m_mcyc = sat(m_mcyc, CMAX);
        end
        x.st = m_st; x.infl = m_infl; x.last = m_last; x.total = m_total; x.inv = m_inv;
        x.stall = m_stall; x.runs = m_runs; x.mcyc = m_mcyc; x.busy = m_busy; x.frz = m_frz;
        expq.push_back(x);
    endtask

    // Monitor: outputs are presented every cycle, so one queued entry per edge
    initial begin
        exp_t x;
        forever begin
            @(posedge clock);
            #1;
            if (expq.size() > 0) begin
                x = expq.pop_front();
                chk("loop_state",   int'(loop_state),   x.st);
                chk("inflight",     int'(inflight),     x.infl);
                chk("last_trip",    int'(last_trip),    x.last);
                chk("iter_total",   int'(iter_total),   x.total);
                chk("invocations",  int'(invocations),  x.inv);
                chk("stall_cycles", int'(stall_cycles), x.stall);
                chk("mod_runs",     int'(mod_runs),     x.runs);
                chk("mod_cycles",   int'(mod_cycles),   x.mcyc);
                chk("mod_busy",     int'(mod_busy),     x.busy);
                chk("frozen",       int'(frozen),       x.frz);
            end
        end
    end

    task automatic tick();
        model_step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic clr_in();
        reset = 0; finish = 0; cur_state = 0;
        iter_start_block = 0; iter_end_block = 0; quit_block = 0;
        iter_start_enable = 1; iter_end_enable = 1; quit_enable = 1;
        loop_start = 0; loop_ready = 0; loop_done = 0; loop_continue = 0;
        ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 0;
    endtask

    task automatic do_reset();
        clr_in(); reset = 1; tick(); reset = 0;
    endtask

    task automatic s_pulse();
        clr_in(); cur_state = iter_start_state; tick();
    endtask

    initial begin
        int wait_cnt;
        iter_start_state = 2'd1; iter_end_state = 2'd2; quit_state = 2'd3;
        quit_at_end = 1;
        clr_in();
        reset = 1;
        tick();
        reset = 0;

        // Five iterations, then done with continue
        clr_in(); loop_start = 1; tick();
        repeat (5) s_pulse();
        clr_in(); loop_done = 1; loop_continue = 1; tick();
        chk("trip5_last_trip", int'(last_trip), 5);
        chk("trip5_iter_total", int'(iter_total), 5);
        chk("trip5_invocations", int'(invocations), 1);
        chk("trip5_idle", int'(loop_state), 0);

        // Simultaneous start and end of iteration
        do_reset();
        clr_in(); loop_start = 1; tick();
        s_pulse(); s_pulse();
        iter_end_state = 2'd1;
        s_pulse();
        iter_end_state = 2'd2;
        chk("se_inflight_hold", int'(inflight), 2);
        clr_in(); loop_done = 1; loop_continue = 1; tick();
        chk("done_inflight_clear", int'(inflight), 0);

        // Wait for continue
        do_reset();
        clr_in(); loop_start = 1; tick();
        clr_in(); loop_done = 1; tick();
        chk("wait_cycle1", int'(loop_state), 2);
        clr_in(); tick();
        chk("wait_cycle2", int'(loop_state), 2);
        clr_in(); tick();
        chk("wait_cycle3", int'(loop_state), 2);
        clr_in(); loop_continue = 1; tick();
        chk("wait_to_idle", int'(loop_state), 0);

        // Stalled start stage
        do_reset();
        clr_in(); loop_start = 1; tick();
        repeat (4) begin clr_in(); cur_state = iter_start_state; iter_start_block = 1; tick(); end
`ifdef UPC_LOOP_MONITOR_STALL_EN
        chk("stall_count", int'(stall_cycles), 4);
`else
        chk("stall_count", int'(stall_cycles), 0);
`endif

        // Module run then freeze
        do_reset();
        clr_in(); ap_start = 1; tick();
        repeat (9) begin clr_in(); tick(); end
        clr_in(); ap_done = 1; ap_continue = 1; tick();
        chk("mod_runs_1", int'(mod_runs), 1);
        chk("mod_cycles_10", int'(mod_cycles), 10);
        chk("mod_busy_clear", int'(mod_busy), 0);
        clr_in(); finish = 1; tick();
        chk("frozen_set", int'(frozen), 1);
        repeat (4) begin clr_in(); ap_start = 1; loop_start = 1; tick(); end
        chk("frozen_state", int'(loop_state), 3);
        chk("frozen_mod_runs", int'(mod_runs), 1);
        chk("frozen_mod_cycles", int'(mod_cycles), 10);
        chk("frozen_invocations", int'(invocations), 0);

        // Saturation at all-ones
        do_reset();
        clr_in(); ap_start = 1; loop_start = 1; tick();
        repeat (20) s_pulse();
        chk("sat_mod_cycles", int'(mod_cycles), 15);
        chk("sat_iter_total", int'(iter_total), 15);
        clr_in(); loop_done = 1; loop_continue = 1; tick();
        chk("sat_last_trip", int'(last_trip), 15);

        // Reset beats finish and loop_start
        clr_in(); reset = 1; finish = 1; loop_start = 1; tick();
        chk("reset_prio_frozen", int'(frozen), 0);
        chk("reset_prio_state", int'(loop_state), 0);
        chk("reset_prio_iter_total", int'(iter_total), 0);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                iter_start_state = STATE_W'($urandom_range(0, 3));
                iter_end_state   = STATE_W'($urandom_range(0, 3));
                quit_state       = STATE_W'($urandom_range(0, 3));
                quit_at_end      = 1'($urandom_range(0, 1));
            end
            reset             = ($urandom_range(0, 79) == 0);
            finish            = ($urandom_range(0, 299) == 0);
            cur_state         = STATE_W'($urandom_range(0, 3));
            iter_start_block  = ($urandom_range(0, 3) == 0);
            iter_end_block    = ($urandom_range(0, 3) == 0);
            quit_block        = ($urandom_range(0, 3) == 0);
            iter_start_enable = ($urandom_range(0, 7) != 0);
            iter_end_enable   = ($urandom_range(0, 7) != 0);
            quit_enable       = ($urandom_range(0, 7) != 0);
            loop_start        = ($urandom_range(0, 3) == 0);
            loop_ready        = 1'($urandom_range(0, 1));
            loop_done         = ($urandom_range(0, 9) == 0);
            loop_continue     = 1'($urandom_range(0, 1));
            ap_start          = ($urandom_range(0, 5) == 0);
            ap_ready          = 1'($urandom_range(0, 1));
            ap_done           = ($urandom_range(0, 7) == 0);
            ap_continue       = 1'($urandom_range(0, 1));
            tick();
        end

        clr_in();
        wait_cnt = 0;
        while (expq.size() > 0 && wait_cnt < 10) begin
            @(negedge clock);
            wait_cnt++;
        end
        chk("scoreboard_drained", expq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/upc_loop_monitor.md
UPC_LOOP_MONITOR -- requirements
Module: upc_loop_monitor

Interface
REQ-001 Parameter STATE_W, default 1: width of the monitored FSM state vector.
REQ-002 Parameter CNT_W, default 32: width of every statistics counter.
REQ-003 clock  in  1  single clock; all logic SHALL be rising-edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 finish  in  1  end-of-simulation/run request; freezes all statistics.
REQ-006 cur_state  in  STATE_W  current state of the observed loop FSM.
REQ-007 iter_start_state / iter_end_state / quit_state  in  STATE_W each  state encodings that mark iteration start, iteration end and quit.
REQ-008 iter_start_block / iter_end_block / quit_block  in  1 each  stall (subdone) qualifiers; 1 = the stage is blocked.
REQ-009 iter_start_enable / iter_end_enable / quit_enable  in  1 each  pipeline-stage enable qualifiers.
REQ-010 loop_start / loop_ready / loop_done / loop_continue  in  1 each  loop block-level handshake.
REQ-011 quit_at_end  in  1  1 = the loop exits on iteration end; 0 = the loop exits on the quit event.
REQ-012 ap_start / ap_ready / ap_done / ap_continue  in  1 each  enclosing non-dataflow module handshake.
REQ-013 loop_state  out  2  loop FSM state; mod_busy  out  1  module-active flag; frozen  out  1  sticky finish flag.
REQ-014 iter_total / invocations / last_trip / stall_cycles / mod_runs / mod_cycles  out  CNT_W each  statistics counters.
REQ-015 inflight  out  8  iterations started but not yet ended.

Function
REQ-016 Events are evaluated per cycle: S = cur_state==iter_start_state && !iter_start_block && iter_start_enable; E = the same using the iter_end_* signals; Q = the same using the quit_* signals.
REQ-017 The loop FSM SHALL have states IDLE(0), RUN(1), WAIT_CONT(2), FROZEN(3).
REQ-018 IDLE->RUN on loop_start; invocations increments and the per-invocation trip counter clears to 0 in that cycle.
REQ-019 RUN: each S increments the trip counter and iter_total; inflight increments on S and decrements on E; a simultaneous S and E leaves inflight unchanged.
REQ-020 Exit: when quit_at_end=1, loop_done closes the invocation; when quit_at_end=0, Q or loop_done closes it, whichever comes first.
REQ-021 On close, last_trip takes the trip count including any S in the same cycle, and inflight clears to 0; then RUN->IDLE if loop_continue=1, else RUN->WAIT_CONT.
REQ-022 WAIT_CONT->IDLE on loop_continue; a loop_start in the same cycle SHALL go directly to RUN.
REQ-023 loop_ready is informational only: it SHALL NOT change state.
REQ-024 Module tracker: mod_busy sets on ap_start while idle, and mod_runs increments at that set.
REQ-025 mod_busy clears on ap_done && ap_continue; ap_done without ap_continue holds busy.
REQ-026 mod_cycles increments every cycle mod_busy=1.
REQ-027 All counters SHALL saturate at all-ones and never wrap; inflight saturates at 255 and floors at 0.
REQ-028 finish=1 in any state SHALL set frozen and move to FROZEN; FROZEN exits only on reset, and all counters hold.

Reset
REQ-029 Reset SHALL force loop_state=IDLE, all counters=0, inflight=0, mod_busy=0 and frozen=0, and SHALL abandon any invocation in flight with no last_trip update.
REQ-030 Reset has priority over finish and over every event in the same cycle.

Configuration
REQ-031 The macro UPC_LOOP_MONITOR_STALL_EN SHALL enable stall counting: stall_cycles increments in RUN when cur_state==iter_start_state && iter_start_enable && iter_start_block.
REQ-032 Without UPC_LOOP_MONITOR_STALL_EN, stall_cycles SHALL be constant 0 and its counter logic SHALL be absent.

Structure
REQ-033 Package upc_loop_monitor_pkg SHALL hold the loop-state enum and the default CNT_W constant.
REQ-034 The saturating counters SHALL be instances of one sub-module, upc_sat_counter (inputs clr, inc; parameter W).

Verification
REQ-035 loop_start, then 5 S pulses, then loop_done with loop_continue=1 and quit_at_end=1 -> last_trip=5, iter_total=5, invocations=1, back in IDLE.
REQ-036 S and E in the same cycle with inflight=2 -> inflight stays 2; loop_done -> inflight=0.
REQ-037 loop_done with loop_continue=0, hold 3 cycles, then loop_continue=1 -> WAIT_CONT for 3 cycles, then IDLE.
REQ-038 With STALL_EN, iter_start_block held for 4 cycles at iter_start_state -> stall_cycles=4; without STALL_EN -> stall_cycles=0.
REQ-039 ap_start, 10 cycles, then ap_done with ap_continue=1 -> mod_runs=1, mod_cycles=10; then finish -> frozen=1 and all counters hold.
REQ-040 Counter preloaded at all-ones with CNT_W=4 and then incremented -> value stays 15.
